// File: rtl/lzd_norm_pipe.sv
// lzd_norm_pipe: two-stage elastic leading-zero / leading-sign detector and
// normalizer. Stage 1 registers the leading count, zero flag and operand;
// stage 2 registers the operand shifted left by that count.
// Optional feature macro: LZN_STATS_EN adds the stat_zero_cnt output, a
// saturating count of output transfers that carried out_zero=1.
module lzd_norm_pipe #(
   parameter int DATA_W = 32,
   localparam int CNT_W = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_zero
`ifdef LZN_STATS_EN
   ,
   output logic [15:0]       stat_zero_cnt
`endif
);

   localparam int LEVELS = $clog2(DATA_W);

   // Detector input. In CLS mode each bit below the MSB is compared with the
   // MSB, so a run of sign copies becomes a run of zeros. The appended 1 stops
   // the count at DATA_W-1 when every bit matches the sign.
   logic [DATA_W-1:0] det_in;
   assign det_in = in_mode
      ? {in_data[DATA_W-2:0] ^ {(DATA_W-1){in_data[DATA_W-1]}}, 1'b1}
      : in_data;

   // Detector tree: level gi holds DATA_W>>gi nodes, each covering 2**gi
   // bits; node 0 of every level covers the most significant slice. A node
   // takes the upper half's count unless the upper half is all zero, in which
   // case it adds the upper half's width to the lower half's count.
   genvar gi, gj;
   generate
      for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
         localparam int N = DATA_W >> gi;
         logic [CNT_W-1:0] cnt  [N];
         logic             zero [N];
         for (gj = 0; gj < N; gj++) begin : g_node
            if (gi == 0) begin : g_leaf
               assign zero[gj] = ~det_in[DATA_W-1-gj];
               assign cnt[gj]  = {{(CNT_W-1){1'b0}}, ~det_in[DATA_W-1-gj]};
            end else begin : g_merge
               assign zero[gj] = g_lvl[gi-1].zero[2*gj] & g_lvl[gi-1].zero[2*gj+1];
               assign cnt[gj]  = g_lvl[gi-1].zero[2*gj]
                  ? CNT_W'(1 << (gi-1)) + g_lvl[gi-1].cnt[2*gj+1]
                  : g_lvl[gi-1].cnt[2*gj];
            end
         end
      end
   endgenerate

   logic [CNT_W-1:0] tree_cnt;
   logic             tree_zero;
   logic             zero_next;
   assign tree_cnt  = g_lvl[LEVELS].cnt[0];
   assign tree_zero = g_lvl[LEVELS].zero[0];
   // CLS detector input is never all zero, so its "no sign change" case is
   // the saturated count DATA_W-1.
   assign zero_next = in_mode ? (tree_cnt == CNT_W'(DATA_W-1)) : tree_zero;

   // Pipeline state and handshake.
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [CNT_W-1:0]  s1_cnt;
   logic              s1_zero;
   logic              s2_valid;
   logic              s1_adv;
   logic              s2_adv;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // Stage 1: capture operand, count and zero flag whenever the stage may move.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_cnt   <= '0;
         s1_zero  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_cnt  <= tree_cnt;
            s1_zero <= zero_next;
         end
      end
   end

   // Stage 2: normalize; contents hold while the result waits for out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
         out_cnt  <= '0;
         out_zero <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= s1_data << s1_cnt;
            out_cnt  <= s1_cnt;
            out_zero <= s1_zero;
         end
      end
   end

`ifdef LZN_STATS_EN
   // Saturating count of delivered results that had out_zero set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_zero_cnt <= '0;
      end else if (out_valid && out_ready && out_zero && (stat_zero_cnt != 16'hFFFF)) begin
         stat_zero_cnt <= stat_zero_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Testbench for lzd_norm_pipe (DATA_W=32): directed vectors with literal
// expectations plus randomized traffic scored against a behavioural model.
module tb_lzd_norm_pipe;

   localparam int DW = 32;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_cnt;
   logic          out_zero;
`ifdef LZN_STATS_EN
   logic [15:0]   stat_zero_cnt;
`endif

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic [CW-1:0] cnt;
      logic          zero;
   } exp_t;

   lzd_norm_pipe #(.DATA_W(DW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_mode(in_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_cnt(out_cnt),
`ifdef LZN_STATS_EN
      .stat_zero_cnt(stat_zero_cnt),
`endif
      .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: count bit by bit from the MSB, exactly as the rules read.
   function automatic exp_t model(input logic [DW-1:0] d, input bit m);
      exp_t e;
      int n;
      n = 0;
      if (!m) begin
         while (n < DW && d[DW-1-n] == 1'b0) n++;
         e.zero = (d == '0);
      end else begin
         while (n < DW-1 && d[DW-2-n] == d[DW-1]) n++;
         e.zero = (d == '0) || (d == '1);
      end
      e.cnt  = CW'(n);
      e.data = d << n;
      return e;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] v;
      v = $urandom;
      v = v >> $urandom_range(0, DW);
      if ($urandom_range(0, 1) == 1) v = ~v;
      return v;
   endfunction

   // One clock cycle: drive at the falling edge, sample 1 ns later, then wait
   // for the rising edge on which any transfer takes place.
   task automatic drive_cycle(input bit iv, input logic [DW-1:0] d, input bit m,
                              input bit ordy, output bit acc, output bit got,
                              output bit ov, output logic [DW-1:0] od,
                              output logic [CW-1:0] oc, output bit oz);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      in_mode   = m;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      ov  = out_valid;
      od  = out_data;
      oc  = out_cnt;
      oz  = out_zero;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_data, out_cnt, out_zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b data=%h cnt=%0d zero=%b, required all 0",
                  out_valid, out_data, out_cnt, out_zero);
      end
`ifdef LZN_STATS_EN
      n_checks++;
      if (stat_zero_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stat: got %0d, required 0", stat_zero_cnt);
      end
`endif
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      $display("test_reset done");
   endtask

   logic [DW-1:0] dir_data [8] = '{32'h0001_0000, 32'h0000_0000, 32'hFFFF_8000, 32'hFFFF_FFFF,
                                   32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
   bit            dir_mode [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   int            dir_cnt  [8] = '{15, 32, 16, 31, 0, 31, 0, 30};
   logic [DW-1:0] dir_out  [8] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000,
                                   32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'h4000_0000};
   bit            dir_zero [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   task automatic test_directed();
      bit acc, got, ov, oz;
      logic [DW-1:0] od;
      logic [CW-1:0] oc;
      int stat_exp;
      stat_exp = 0;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, dir_data[i], dir_mode[i], 1'b1, acc, got, ov, od, oc, oz);
         n_checks++;
         if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_accept[%0d]: got accepted=%b, required 1", i, acc);
         end
         drive_cycle(1'b0, '0, 1'b0, 1'b1, acc, got, ov, od, oc, oz);
         n_checks++;
         if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_latency_early[%0d]: got out_valid=%b one cycle after input, required 0", i, ov);
         end
         drive_cycle(1'b0, '0, 1'b0, 1'b1, acc, got, ov, od, oc, oz);
         n_checks++;
         if (got !== 1'b1 || oc !== CW'(dir_cnt[i]) || od !== dir_out[i] || oz !== dir_zero[i]) begin
            n_fail++;
            $display("FAIL dir_result[%0d]: in=%h mode=%b got valid=%b cnt=%0d data=%h zero=%b, required valid=1 cnt=%0d data=%h zero=%b",
                     i, dir_data[i], dir_mode[i], got, oc, od, oz, dir_cnt[i], dir_out[i], dir_zero[i]);
         end
         if (dir_zero[i]) stat_exp++;
`ifdef LZN_STATS_EN
         #1;
         n_checks++;
         if (stat_zero_cnt !== 16'(stat_exp)) begin
            n_fail++;
            $display("FAIL dir_stat[%0d]: got %0d, required %0d", i, stat_zero_cnt, stat_exp);
         end
`endif
         $display("directed %0d: in=%h mode=%b -> cnt=%0d data=%h zero=%b", i, dir_data[i], dir_mode[i], oc, od, oz);
      end
   endtask

   task automatic test_backpressure();
      bit acc, got, ov, oz;
      logic [DW-1:0] od, hold_d;
      logic [CW-1:0] oc, hold_c;
      int sent, rcvd, c;
      sent = 0;
      rcvd = 0;
      c = 0;
      hold_d = '0;
      hold_c = '0;
      while (rcvd < 3 && c < 30) begin
         drive_cycle(sent < 3, DW'(1) << sent, 1'b0, c >= 4, acc, got, ov, od, oc, oz);
         if (c == 2 || c == 3) begin
            n_checks++;
            if (acc !== 1'b0 || sent != 2) begin
               n_fail++;
               $display("FAIL bp_in_ready[c=%0d]: got accepted=%b after %0d beats, required 0 after 2", c, acc, sent);
            end
         end
         if (c == 2) begin
            hold_d = od;
            hold_c = oc;
         end
         if (c == 3) begin
            n_checks++;
            if (ov !== 1'b1 || od !== hold_d || oc !== hold_c) begin
               n_fail++;
               $display("FAIL bp_hold: got valid=%b data=%h cnt=%0d, required valid=1 data=%h cnt=%0d",
                        ov, od, oc, hold_d, hold_c);
            end
         end
         if (acc) sent++;
         if (got) begin
            n_checks++;
            if (oc !== CW'(31 - rcvd) || od !== 32'h8000_0000 || oz !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_order[%0d]: got cnt=%0d data=%h zero=%b, required cnt=%0d data=80000000 zero=0",
                        rcvd, oc, od, oz, 31 - rcvd);
            end
            $display("backpressure out %0d: cnt=%0d data=%h", rcvd, oc, od);
            rcvd++;
         end
         c++;
      end
      n_checks++;
      if (rcvd != 3) begin
         n_fail++;
         $display("FAIL bp_timeout: got %0d results, required 3", rcvd);
      end
   endtask

   task automatic test_alternating();
      bit acc, got, ov, oz;
      logic [DW-1:0] od, d;
      logic [CW-1:0] oc;
      exp_t q[$];
      exp_t e;
      for (int c = 0; c < 18; c++) begin
         d = rand_data();
         drive_cycle(c < 16, d, c[0], 1'b1, acc, got, ov, od, oc, oz);
         n_checks++;
         if (acc !== (c < 16) || got !== (c >= 2)) begin
            n_fail++;
            $display("FAIL alt_rate[c=%0d]: got accepted=%b delivered=%b, required %b %b", c, acc, got, c < 16, c >= 2);
         end
         if (got) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL alt_extra: got cnt=%0d data=%h with nothing outstanding, required no result", oc, od);
            end else begin
               e = q.pop_front();
               n_checks++;
               if (oc !== e.cnt || od !== e.data || oz !== e.zero) begin
                  n_fail++;
                  $display("FAIL alt_result[c=%0d]: got cnt=%0d data=%h zero=%b, required cnt=%0d data=%h zero=%b",
                           c, oc, od, oz, e.cnt, e.data, e.zero);
               end
               $display("alternating c=%0d: cnt=%0d data=%h zero=%b", c, oc, od, oz);
            end
         end
         if (acc) q.push_back(model(d, c[0]));
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL alt_drain: got %0d results outstanding, required 0", q.size());
      end
   endtask

   task automatic test_random();
      bit acc, got, ov, oz, iv, m, ordy, stalled;
      logic [DW-1:0] od, d, hold_d;
      logic [CW-1:0] oc, hold_c;
      bit hold_z;
      exp_t q[$];
      exp_t e;
      int c;
      stalled = 1'b0;
      hold_d = '0;
      hold_c = '0;
      hold_z = 1'b0;
      c = 0;
      while (c < 400 || (q.size() != 0 && c < 440)) begin
         iv   = (c < 400) && ($urandom_range(0, 9) < 7);
         d    = rand_data();
         m    = 1'($urandom_range(0, 1));
         ordy = (c >= 400) || ($urandom_range(0, 9) < 6);
         drive_cycle(iv, d, m, ordy, acc, got, ov, od, oc, oz);
         if (stalled) begin
            n_checks++;
            if (ov !== 1'b1 || od !== hold_d || oc !== hold_c || oz !== hold_z) begin
               n_fail++;
               $display("FAIL rnd_hold[c=%0d]: got valid=%b cnt=%0d data=%h zero=%b, required valid=1 cnt=%0d data=%h zero=%b",
                        c, ov, oc, od, oz, hold_c, hold_d, hold_z);
            end
         end
         if (got) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rnd_extra[c=%0d]: got cnt=%0d data=%h with nothing outstanding, required no result", c, oc, od);
            end else begin
               e = q.pop_front();
               n_checks++;
               if (oc !== e.cnt || od !== e.data || oz !== e.zero) begin
                  n_fail++;
                  $display("FAIL rnd_result[c=%0d]: got cnt=%0d data=%h zero=%b, required cnt=%0d data=%h zero=%b",
                           c, oc, od, oz, e.cnt, e.data, e.zero);
               end
            end
         end
         if (acc) q.push_back(model(d, m));
         stalled = ov && !ordy;
         hold_d = od;
         hold_c = oc;
         hold_z = oz;
         c++;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL rnd_drain: got %0d results outstanding, required 0", q.size());
      end
      $display("test_random done: %0d cycles", c);
   endtask

   task automatic test_reset_mid();
      bit acc, got, ov, oz;
      logic [DW-1:0] od;
      logic [CW-1:0] oc;
      int sent;
      sent = 0;
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b1, 32'h0000_00F0 << i, 1'b0, 1'b0, acc, got, ov, od, oc, oz);
         if (acc) sent++;
      end
      n_checks++;
      if (sent != 2) begin
         n_fail++;
         $display("FAIL rstmid_fill: got %0d beats accepted, required 2", sent);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_state: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
`ifdef LZN_STATS_EN
      n_checks++;
      if (stat_zero_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_stat: got %0d, required 0", stat_zero_cnt);
      end
`endif
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, '0, 1'b0, 1'b1, acc, got, ov, od, oc, oz);
         n_checks++;
         if (got !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stale[%0d]: got result cnt=%0d data=%h, required none", i, oc, od);
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_alternating();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
